coda_registri: RTL and testbench
================================

# coda_registri

Parametrised FIFO queue built from a bank of write-enabled registers. It generalises the single 8-bit write-enabled register to DEPTH entries of WIDTH bits, with valid/ready handshakes on both sides, occupancy tracking and synchronous flush. It sits between a producer and a consumer stage that run on the same clock and need decoupling of up to DEPTH words.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of storage entries; power of two, ≥2
- clock  input  1  single clock; all state updates on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of queue contents, active-high
- in_data  input  WIDTH  word offered by the producer
- in_valid  input  1  producer offers in_data this cycle
- in_ready  output  1  queue can accept a word this cycle
- out_data  output  WIDTH  word at the head of the queue
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer takes out_data this cycle
- count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH

## Operation
- State: storage mem[0..DEPTH-1], write pointer wp and read pointer rp (each $clog2(DEPTH) bits), occupancy count.
- Push = in_valid && in_ready. On push: mem[wp] <= in_data; wp <= wp+1, wrapping modulo DEPTH (DEPTH-1 → 0).
- Pop = out_valid && out_ready. On pop: rp <= rp+1, wrapping modulo DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on push and pop in the same cycle, unchanged when neither occurs.
- in_ready = (count != DEPTH); combinational from registered state only; never depends on out_ready. When full, a push is refused even if a pop occurs the same cycle.
- out_valid = (count != 0); out_data = mem[rp] (first-word fall-through: the head is visible without a request). When count == 0, out_data is don't-care and the bench does not check it.
- Empty: out_valid = 0, so no pop is possible; a push raises out_valid on the next cycle.
- Full (count == DEPTH): in_ready = 0; in_valid is ignored; stored data is never overwritten.
- flush = 1 at a rising edge: wp, rp and count go to 0; push and pop in that cycle are discarded. flush has priority over everything except reset_n. mem contents are not cleared.
- Words leave in exactly the order they were accepted. No word is duplicated or dropped except by flush or reset.
- Producer and consumer may hold valid/data while the other side is not ready. The queue samples in_data only on push.

## Timing
- Reset (reset_n = 0, asynchronous, independent of clock): wp = rp = 0, count = 0, all mem entries = 0. Hence out_valid = 0, in_ready = 1, out_data = 0. The reset state holds for as long as reset_n is low.
- Reset asserted mid-operation, including mid-handshake: all queued words are lost immediately. The first push is accepted at the first rising edge after reset_n returns high.
- Latency: a word pushed at edge N appears at out_data with out_valid = 1 immediately after edge N if the queue was empty; minimum fall-through latency is 1 cycle.
- count, in_ready and out_valid change only after a rising edge or on reset. They are glitch-free functions of registered state.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.

## Test plan
- Reset: hold reset_n = 0 with in_valid = 1 and in_data = 8'hAA while clocking → count = 0, out_valid = 0, in_ready = 1, out_data = 0; release reset_n → the first push of 8'h07 gives out_data = 8'h07 and count = 1 after one edge.
- Fill/full: push 7, 12, 5, 9 with out_ready = 0 → count = 4, in_ready = 0; offer 8'h33 for three cycles → not stored, count stays 4.
- Drain order and empty: from the full state {7, 12, 5, 9}, hold out_ready = 1 → out_data sequence 7, 12, 5, 9 on successive cycles, then out_valid = 0 and count = 0; extra cycles with out_ready = 1 leave count at 0.
- Simultaneous push/pop with wrap: keep count = 2 while pushing 1..10 and popping each cycle → popped stream is in order with no loss across pointer wrap 3 → 0; count stays 2 throughout. When full, push+pop → pop only, count 4 → 3.
- Flush: with count = 3, assert flush together with in_valid = 1 (8'h44) and out_ready = 1 → next cycle count = 0, out_valid = 0, 8'h44 not stored.
- Async reset mid-operation: with count = 2, drop reset_n between clock edges → outputs take reset values before the next edge.

Source files
------------

// File: rtl/coda_registri_if.sv
// Producer/consumer handshake bundle for coda_registri: push side, pop side, flush and occupancy.
// The master modport is the surrounding logic; the slave modport is the queue itself.
interface coda_registri_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count
    );

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count
    );
endinterface

// File: rtl/coda_registri.sv
// Register-bank FIFO, DEPTH x WIDTH, first-word fall-through (push visible 1 cycle later).
// in_ready drops only when full and never looks at out_ready; flush clears pointers and count.
module coda_registri #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    coda_registri_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop, wr_en;

    assign q.in_ready  = (cnt_q != CW'(DEPTH));
    assign q.out_valid = (cnt_q != '0);
    assign q.out_data  = mem_q[rp_q];
    assign q.count     = cnt_q;

    assign push  = q.in_valid  && q.in_ready;
    assign pop   = q.out_valid && q.out_ready;
    assign wr_en = push && !q.flush;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (q.flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (pop && !push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wp_q] <= q.in_data;
        end
    end
endmodule

// File: tb/tb_coda_registri.sv
// Directed bench for coda_registri with a queue scoreboard of accepted words.
module tb_coda_registri;
    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] sb[$];
    int         mcount;

    coda_registri_if #(.WIDTH(8), .DEPTH(4)) qif ();

    coda_registri #(.WIDTH(8), .DEPTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .q       (qif)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic post_edge_checks(input string tag);
        chk({tag, " count"}, 32'(qif.count), 32'(mcount));
        chk({tag, " in_ready"}, 32'(qif.in_ready), 32'(mcount != 4));
        chk({tag, " out_valid"}, 32'(qif.out_valid), 32'(mcount != 0));
        if (mcount != 0) chk({tag, " head"}, 32'(qif.out_data), 32'(sb[0]));
    endtask

    // Entered at posedge+1; drives one cycle's inputs, updates the model, checks after the edge.
    task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                         input logic r, input logic f);
        logic acc_push, acc_pop;
        qif.in_valid  = v;
        qif.in_data   = d;
        qif.out_ready = r;
        qif.flush     = f;
        #4;
        acc_push = v && (mcount != 4);
        acc_pop  = r && (mcount != 0);
        if (acc_pop && !f) chk({tag, " pop data"}, 32'(qif.out_data), 32'(sb[0]));
        if (f) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (acc_pop) begin
                void'(sb.pop_front());
                mcount--;
            end
            if (acc_push) begin
                sb.push_back(d);
                mcount++;
            end
        end
        @(posedge clock);
        #1;
        post_edge_checks(tag);
    endtask

    initial begin
        sb.delete();
        mcount        = 0;
        reset_n       = 1'b0;
        qif.flush     = 1'b0;
        qif.in_valid  = 1'b1;
        qif.in_data   = 8'hAA;
        qif.out_ready = 1'b0;

        // Reset held while the producer offers data
        repeat (3) @(posedge clock);
        #1;
        chk("reset count", 32'(qif.count), 32'd0);
        chk("reset out_valid", 32'(qif.out_valid), 32'd0);
        chk("reset in_ready", 32'(qif.in_ready), 32'd1);
        chk("reset out_data", 32'(qif.out_data), 32'h0);
        reset_n = 1'b1;

        cycle("first push", 1'b1, 8'h07, 1'b0, 1'b0);
        chk("first out_data", 32'(qif.out_data), 32'h07);
        chk("first count", 32'(qif.count), 32'd1);

        // Fill to full, then offer while full
        cycle("fill 12", 1'b1, 8'd12, 1'b0, 1'b0);
        cycle("fill 5",  1'b1, 8'd5,  1'b0, 1'b0);
        cycle("fill 9",  1'b1, 8'd9,  1'b0, 1'b0);
        chk("full count", 32'(qif.count), 32'd4);
        chk("full in_ready", 32'(qif.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) cycle("full refuse", 1'b1, 8'h33, 1'b0, 1'b0);

        // Drain in order, then idle pops on empty
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty count", 32'(qif.count), 32'd0);
        chk("empty out_valid", 32'(qif.out_valid), 32'd0);
        for (int i = 0; i < 2; i++) cycle("empty pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Steady push+pop at count 2 across pointer wrap
        cycle("pre 1", 1'b1, 8'd1, 1'b0, 1'b0);
        cycle("pre 2", 1'b1, 8'd2, 1'b0, 1'b0);
        for (int i = 3; i <= 10; i++) begin
            cycle("stream", 1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream count", 32'(qif.count), 32'd2);
        end

        // Full with simultaneous push and pop: pop only
        cycle("refill 11", 1'b1, 8'd11, 1'b0, 1'b0);
        cycle("refill 12", 1'b1, 8'd12, 1'b0, 1'b0);
        chk("refull count", 32'(qif.count), 32'd4);
        cycle("full push+pop", 1'b1, 8'd13, 1'b1, 1'b0);
        chk("full push+pop count", 32'(qif.count), 32'd3);

        // Flush with push and pop offered
        cycle("flush", 1'b1, 8'h44, 1'b1, 1'b1);
        chk("flush count", 32'(qif.count), 32'd0);
        chk("flush out_valid", 32'(qif.out_valid), 32'd0);
        cycle("post flush push", 1'b1, 8'h55, 1'b0, 1'b0);
        cycle("post flush pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges with two words queued
        cycle("pre rst a", 1'b1, 8'hA1, 1'b0, 1'b0);
        cycle("pre rst b", 1'b1, 8'hB2, 1'b0, 1'b0);
        qif.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        mcount = 0;
        chk("async count", 32'(qif.count), 32'd0);
        chk("async out_valid", 32'(qif.out_valid), 32'd0);
        chk("async in_ready", 32'(qif.in_ready), 32'd1);
        chk("async out_data", 32'(qif.out_data), 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cycle("after rst push", 1'b1, 8'h3C, 1'b0, 1'b0);
        cycle("after rst pop", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
